// File: rtl/cell_tester_pkg.sv
// cell_tester_pkg: shared cell-select and FSM types, step counts and Gray stepping.
package cell_tester_pkg;
  typedef enum logic [1:0] {CELL_MUX2I, CELL_MAJ3, CELL_DLRTP, CELL_DFRTP} cell_e;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_FINISH} state_e;
  localparam int COMB_STEPS = 8;
  localparam int SEQ_STEPS = 16;
  function automatic logic [2:0] gray_step(input logic [3:0] i);
    return i[2:0] ^ {1'b0, i[2:1]};
  endfunction
  function automatic logic is_seq(input cell_e c);
    return c == CELL_DLRTP || c == CELL_DFRTP;
  endfunction
endpackage

// File: rtl/cell_golden_model.sv
// cell_golden_model: expected cell output for the current vector, with the state the sequential cells hold.
module cell_golden_model
  import cell_tester_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  cell_e      sel,
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output logic       expected
);
  logic q;
  logic seq_next;
  logic maj;
  always_comb begin
    maj = (cur[0] & cur[1]) | (cur[0] & cur[2]) | (cur[1] & cur[2]);
    seq_next = !cur[2] ? 1'b0
             : sel == CELL_DLRTP ? (cur[1] ? cur[0] : q)
             : (!prev[1] && cur[1]) ? cur[0] : q;
    expected = sel == CELL_MUX2I ? ~(cur[2] ? cur[1] : cur[0])
             : sel == CELL_MAJ3 ? maj
             : seq_next;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (step && is_seq(sel)) q <= seq_next;
endmodule

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer: walks a Gray-coded stimulus over a library cell and checks its output against a golden model.
module cell_test_sequencer
  import cell_tester_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] SEL,
  input  logic [3:0] SETTLE,
  input  logic       CUT_Y,
  output logic [2:0] STIM,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_COUNT,
  output logic [3:0] FAIL_STEP
);
  state_e state;
  cell_e sel_q;
  logic [3:0] settle_q, cnt, step;
  logic [2:0] prev;
  logic cut_q, expected, accept, mismatch, last;
  always_comb begin
    accept = state == S_IDLE && START;
    mismatch = state == S_CHECK && cut_q != expected;
    last = step == (is_seq(sel_q) ? 4'(SEQ_STEPS - 1) : 4'(COMB_STEPS - 1));
  end
  cell_golden_model golden (
    .clk(CLK),
    .rst(RESET),
    .clr(accept),
    .step(state == S_CHECK),
    .sel(sel_q),
    .prev(prev),
    .cur(STIM),
    .expected(expected)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= S_IDLE;
      sel_q <= CELL_MUX2I;
      settle_q <= 4'd0;
      cnt <= 4'd0;
      step <= 4'd0;
      prev <= 3'd0;
      cut_q <= 1'b0;
      STIM <= 3'd0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      PASS <= 1'b0;
      ERR_COUNT <= 4'd0;
      FAIL_STEP <= 4'd0;
    end else begin
      cut_q <= CUT_Y;
      DONE <= 1'b0;
      case (state)
        S_IDLE:
          if (START) begin
            sel_q <= cell_e'(SEL);
            settle_q <= SETTLE;
            step <= 4'd0;
            prev <= STIM;
            STIM <= gray_step(4'd0);
            BUSY <= 1'b1;
            PASS <= 1'b0;
            ERR_COUNT <= 4'd0;
            FAIL_STEP <= 4'd0;
            state <= S_APPLY;
          end
        S_APPLY: begin
          cnt <= settle_q - 4'd1;
          state <= settle_q == 4'd0 ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (ERR_COUNT != 4'd15) ERR_COUNT <= ERR_COUNT + 4'd1;
            if (ERR_COUNT == 4'd0) FAIL_STEP <= step;
          end
          if (last) state <= S_FINISH;
          else begin
            step <= step + 4'd1;
            prev <= STIM;
            STIM <= gray_step(step + 4'd1);
            state <= S_APPLY;
          end
        end
        S_FINISH: begin
          DONE <= 1'b1;
          BUSY <= 1'b0;
          STIM <= 3'd0;
          PASS <= ERR_COUNT == 4'd0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb_cell_test_sequencer: directed runs against behavioural cells with hand-computed results.
module tb_cell_test_sequencer;
  logic CLK = 1'b0, RESET = 1'b1, START = 1'b0, CUT_Y;
  logic [1:0] SEL = 2'd0;
  logic [3:0] SETTLE = 4'd0;
  logic [2:0] STIM;
  logic BUSY, DONE, PASS;
  logic [3:0] ERR_COUNT, FAIL_STEP;
  int vectors = 0, miscompares = 0, mode = 0, cyc, maxd, dones;
  logic busy_mid;
  logic ff_q = 1'b0, dl_q, maj, mux_y;

  cell_test_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SEL(SEL), .SETTLE(SETTLE), .CUT_Y(CUT_Y),
    .STIM(STIM), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT), .FAIL_STEP(FAIL_STEP)
  );

  always #5 CLK = ~CLK;

  // Behavioural cells driven straight from STIM (mode 0/5 tie low/high, 3 inverts the latch)
  always @(posedge STIM[1] or negedge STIM[2])
    if (!STIM[2]) ff_q <= 1'b0;
    else ff_q <= STIM[0];
  always_latch
    if (!STIM[2]) dl_q <= 1'b0;
    else if (STIM[1]) dl_q <= STIM[0];
  assign maj = (STIM[0] + STIM[1] + STIM[2]) >= 2;
  assign mux_y = !(STIM[2] ? STIM[1] : STIM[0]);
  assign CUT_Y = mode == 1 ? maj : mode == 2 ? ff_q : mode == 3 ? !dl_q
               : mode == 4 ? mux_y : mode == 5 ? 1'b1 : mode == 6 ? dl_q : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] sel, input logic [3:0] settle, input int m, input int poke);
    logic [2:0] ps;
    mode = m;
    @(negedge CLK);
    SEL = sel;
    SETTLE = settle;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    cyc = 0;
    maxd = 0;
    dones = 0;
    busy_mid = 1'b0;
    ps = STIM;
    while (cyc < 400 && dones == 0) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      START = (cyc == poke);
      if (cyc == poke) SEL = ~sel;
      if ($countones(STIM ^ ps) > maxd) maxd = $countones(STIM ^ ps);
      ps = STIM;
      if (cyc == 1) busy_mid = BUSY;
      if (DONE) dones++;
    end
    START = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
  endtask

  initial begin
    #3;
    chk("rst_stim", STIM, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pass", PASS, 0);
    chk("rst_err", ERR_COUNT, 0);
    chk("rst_fstep", FAIL_STEP, 0);
    @(negedge CLK);
    RESET = 1'b0;

    run(2'd1, 4'd2, 1, -1);
    chk("maj3_latency", cyc, 33);
    chk("maj3_busy_mid", busy_mid, 1);
    chk("maj3_pass", PASS, 1);
    chk("maj3_err", ERR_COUNT, 0);
    chk("maj3_busy_end", BUSY, 0);
    chk("maj3_stim_end", STIM, 0);
    chk("maj3_dones", dones, 1);

    run(2'd0, 4'd0, 0, -1);
    chk("mux_lo_latency", cyc, 17);
    chk("mux_lo_err", ERR_COUNT, 4);
    chk("mux_lo_fstep", FAIL_STEP, 0);
    chk("mux_lo_pass", PASS, 0);

    run(2'd0, 4'd3, 5, -1);
    chk("mux_hi_latency", cyc, 41);
    chk("mux_hi_err", ERR_COUNT, 4);
    chk("mux_hi_fstep", FAIL_STEP, 1);
    chk("mux_hi_pass", PASS, 0);

    run(2'd3, 4'd0, 2, -1);
    chk("dfrtp_latency", cyc, 33);
    chk("dfrtp_pass", PASS, 1);
    chk("dfrtp_err", ERR_COUNT, 0);
    chk("dfrtp_onebit", maxd, 1);

    run(2'd2, 4'd1, 3, -1);
    chk("dlrtp_inv_latency", cyc, 49);
    chk("dlrtp_inv_err", ERR_COUNT, 15);
    chk("dlrtp_inv_fstep", FAIL_STEP, 0);
    chk("dlrtp_inv_pass", PASS, 0);

    run(2'd2, 4'd0, 6, -1);
    chk("dlrtp_pass", PASS, 1);
    chk("dlrtp_err", ERR_COUNT, 0);

    mode = 1;
    @(negedge CLK);
    SEL = 2'd1;
    SETTLE = 4'd2;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (21) @(posedge CLK);
    @(negedge CLK);
    chk("step5_stim", STIM, 7);
    chk("step5_busy", BUSY, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_busy", BUSY, 0);
    chk("async_stim", STIM, 0);
    chk("async_err", ERR_COUNT, 0);
    RESET = 1'b0;

    run(2'd0, 4'd1, 4, -1);
    chk("post_rst_latency", cyc, 25);
    chk("post_rst_pass", PASS, 1);
    chk("post_rst_err", ERR_COUNT, 0);

    run(2'd1, 4'd0, 1, 5);
    chk("poke_latency", cyc, 17);
    chk("poke_pass", PASS, 1);
    chk("poke_dones", dones, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cell_test_sequencer.md
CELL_TEST_SEQUENCER -- requirements
Module: cell_test_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port START, input, 1: run request, sampled only in IDLE.
REQ-004 SHALL have port SEL, input, 2: cell under test (0 mux2i, 1 maj3, 2 dlrtp, 3 dfrtp), latched at START.
REQ-005 SHALL have port SETTLE, input, 4: extra wait cycles per step, latched at START.
REQ-006 SHALL have port CUT_Y, input, 1: output of selected cell.
REQ-007 SHALL have port STIM, output, 3, registered: cell inputs.
- mux2i: [0] A0, [1] A1, [2] S.
- maj3: [0] A, [1] B, [2] C.
- dlrtp: [0] D, [1] GATE, [2] RESET_B.
- dfrtp: [0] D, [1] CLK, [2] RESET_B.
REQ-008 SHALL have port BUSY, output, 1: run in progress.
REQ-009 SHALL have port DONE, output, 1: one-cycle end-of-run pulse.
REQ-010 SHALL have port PASS, output, 1: ERR_COUNT==0, held from DONE until next accepted START.
REQ-011 SHALL have port ERR_COUNT, output, 4: mismatches, saturating at 15.
REQ-012 SHALL have port FAIL_STEP, output, 4: step index of first mismatch, 0 if none.

Function
REQ-013 SHALL apply the Gray sequence 000,001,011,010,110,111,101,100 so that exactly one STIM bit changes per step, including at wrap.
REQ-014 SHALL run 8 steps for combinational cells (SEL 0,1) and 16 steps (two passes) for sequential cells (SEL 2,3).
REQ-015 SHALL implement FSM IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | FINISH) -> IDLE.
REQ-016 SHALL load STIM on entry to APPLY; APPLY lasts 1 cycle.
REQ-017 WAIT SHALL last SETTLE cycles; SETTLE=0 skips WAIT.
REQ-018 CHECK SHALL last 1 cycle, giving 2+SETTLE cycles per step.
REQ-019 SHALL register CUT_Y every cycle; CHECK SHALL compare the registered value against the golden expectation.
REQ-020 Golden model:
- mux2i: ~(S?A1:A0).
- maj3: majority of the three inputs.
- dlrtp: !RESET_B -> 0; else GATE -> D; else hold.
- dfrtp: !RESET_B -> 0; else CLK 0->1 between previous and current vector -> D; else hold.
REQ-021 Golden state SHALL clear to 0 at START; step 0 (000) drives RESET_B low for sequential cells.
REQ-022 On mismatch ERR_COUNT SHALL increment, saturating at 15; FAIL_STEP SHALL be written only on the first mismatch of a run.
REQ-023 FINISH SHALL assert DONE for 1 cycle, deassert BUSY, and return STIM to 000.
REQ-024 DONE SHALL occur steps*(2+SETTLE)+1 cycles after the START-accepting edge.
REQ-025 START while BUSY SHALL be ignored; SEL/SETTLE changes mid-run SHALL be ignored.
REQ-026 An accepted START SHALL clear ERR_COUNT, FAIL_STEP and PASS.

Reset
REQ-027 RESET SHALL immediately force IDLE, STIM=000, BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FAIL_STEP=0, and golden state 0, including mid-run.

Structure
REQ-028 Package cell_tester_pkg SHALL hold the cell-select enum, FSM state enum, Gray-step function, and step-count constants (8/16).
REQ-029 Golden computation plus its state register SHALL be sub-module cell_golden_model (inputs: SEL, previous/current vector, step strobe).

Verification
REQ-030 SEL=1, SETTLE=2, behavioural maj3 on CUT_Y -> DONE 33 cycles after START, PASS=1, ERR_COUNT=0.
REQ-031 SEL=0, CUT_Y tied 0 -> ERR_COUNT=4, FAIL_STEP=0, PASS=0.
REQ-032 SEL=3, SETTLE=0, behavioural dfrtp -> DONE 33 cycles after START, PASS=1; STIM never changes more than 1 bit per step.
REQ-033 SEL=2, CUT_Y = inverted behavioural dlrtp -> ERR_COUNT saturates at 15, PASS=0.
REQ-034 RESET pulsed during step 5 -> BUSY=0 and STIM=000 without a clock edge; next START completes a full clean run.
REQ-035 START re-pulsed and SEL changed mid-run -> run unaffected, single DONE.
